// File: rtl/load_hazard_ctrl.sv
// rtl/load_hazard_ctrl.sv - load-use / WAW / queue-depth hazard stall for decode
module load_hazard_ctrl #(
  parameter int NUM_REGS    = 32,
  parameter int MAX_PENDING = 2,
  parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid_i,
  input  logic [4:0]       dec_rs1_addr_i,
  input  logic             dec_rs1_used_i,
  input  logic [4:0]       dec_rs2_addr_i,
  input  logic             dec_rs2_used_i,
  input  logic [4:0]       dec_rd_addr_i,
  input  logic             dec_load_i,
  input  logic             issue_i,
  input  logic             flush_i,
  input  logic             wb_load_done_i,
  input  logic [4:0]       wb_rd_addr_i,
  output logic             stall_o,
  output logic [CNT_W-1:0] pending_cnt_o,
  output logic             busy_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  logic [NUM_REGS-1:0] r_sb;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_err;

  logic [NUM_REGS-1:0] w_clr;
  logic [NUM_REGS-1:0] w_eff;
  logic [NUM_REGS-1:0] w_setv;
  logic                w_rs1_pend;
  logic                w_rs2_pend;
  logic                w_rd_pend;
  logic                w_underflow;
  logic [CNT_W-1:0]    w_cnt_eff;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_full;
  logic                w_set;
  logic                w_hazard;
  logic                w_stall;
  logic                w_err_evt;

  // Writeback in this cycle is visible to decode immediately (bypass), so eff
  // drops the retiring register before the hazard lookups.
  always_comb begin
    w_clr      = '0;
    w_setv     = '0;
    w_rs1_pend = 1'b0;
    w_rs2_pend = 1'b0;
    w_rd_pend  = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (wb_load_done_i && (wb_rd_addr_i == 5'(i))) w_clr[i] = 1'b1;
    end
    w_eff    = r_sb & ~w_clr;
    w_eff[0] = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (dec_rs1_addr_i == 5'(i)) w_rs1_pend = w_eff[i];
      if (dec_rs2_addr_i == 5'(i)) w_rs2_pend = w_eff[i];
      if (dec_rd_addr_i == 5'(i))  w_rd_pend  = w_eff[i];
      if (w_set && (dec_rd_addr_i == 5'(i))) w_setv[i] = 1'b1;
    end
  end

  // A retire with nothing outstanding is an error; the count holds at zero.
  assign w_underflow = wb_load_done_i && (r_cnt == '0);
  assign w_cnt_eff   = (wb_load_done_i && !w_underflow) ? (r_cnt - ONE_CNT) : r_cnt;
  assign w_full      = (w_cnt_eff == MAX_CNT);

  assign w_hazard = (dec_rs1_used_i && w_rs1_pend) ||
                    (dec_rs2_used_i && w_rs2_pend) ||
                    (dec_load_i && w_rd_pend) ||
                    (dec_load_i && w_full);
  assign w_stall  = !rst && dec_valid_i && !flush_i && w_hazard;

  assign w_set     = issue_i && dec_load_i && !flush_i;
  assign w_cnt_nxt = (w_set && !w_full) ? (w_cnt_eff + ONE_CNT) : w_cnt_eff;
  assign w_err_evt = w_underflow || (issue_i && w_stall) || (w_set && w_full);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb  <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_sb  <= w_eff | w_setv;
      r_cnt <= w_cnt_nxt;
      r_err <= r_err || w_err_evt;
    end
  end

  assign stall_o       = w_stall;
  assign pending_cnt_o = r_cnt;
  assign busy_o        = (r_cnt != '0);
  assign err_o         = r_err;

endmodule

// File: tb/tb_load_hazard_ctrl.sv
// tb/tb_load_hazard_ctrl.sv - directed self-checking bench for load_hazard_ctrl
module tb_load_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_valid_i;
  logic [4:0] dec_rs1_addr_i;
  logic       dec_rs1_used_i;
  logic [4:0] dec_rs2_addr_i;
  logic       dec_rs2_used_i;
  logic [4:0] dec_rd_addr_i;
  logic       dec_load_i;
  logic       issue_i;
  logic       flush_i;
  logic       wb_load_done_i;
  logic [4:0] wb_rd_addr_i;
  logic       stall_o;
  logic [1:0] pending_cnt_o;
  logic       busy_o;
  logic       err_o;

  int total = 0;
  int bad   = 0;

  load_hazard_ctrl #(.NUM_REGS(32), .MAX_PENDING(2)) dut (
    .clk(clk), .rst(rst),
    .dec_valid_i(dec_valid_i),
    .dec_rs1_addr_i(dec_rs1_addr_i), .dec_rs1_used_i(dec_rs1_used_i),
    .dec_rs2_addr_i(dec_rs2_addr_i), .dec_rs2_used_i(dec_rs2_used_i),
    .dec_rd_addr_i(dec_rd_addr_i), .dec_load_i(dec_load_i),
    .issue_i(issue_i), .flush_i(flush_i),
    .wb_load_done_i(wb_load_done_i), .wb_rd_addr_i(wb_rd_addr_i),
    .stall_o(stall_o), .pending_cnt_o(pending_cnt_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, then settle for combinational checks.
  task automatic drv(input logic v, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                     input logic ld, input logic iss, input logic fl,
                     input logic wb, input logic [4:0] wbrd);
    dec_valid_i = v;  dec_rs1_addr_i = rs1; dec_rs1_used_i = u1;
    dec_rs2_addr_i = rs2; dec_rs2_used_i = u2; dec_rd_addr_i = rd;
    dec_load_i = ld; issue_i = iss; flush_i = fl;
    wb_load_done_i = wb; wb_rd_addr_i = wbrd;
    #1;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step();
    step();
    // 1: reset state; stall forced low while rst is high
    drv(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("rst_stall", stall_o, 0);
    chk("rst_cnt", pending_cnt_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    rst = 1'b0;

    // 2: lw x5 then add x6,x5,x1
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("t2_issue_stall", stall_o, 0);
    step();
    chk("t2_cnt1", pending_cnt_o, 1);
    chk("t2_busy1", busy_o, 1);
    drv(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("t2_use_stall", stall_o, 1);
    step();
    chk("t2_use_stall_hold", stall_o, 1);
    drv(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
    chk("t2_bypass_stall", stall_o, 0);
    step();
    idle();
    chk("t2_cnt0", pending_cnt_o, 0);
    chk("t2_busy0", busy_o, 0);

    // 3: fill queue, then retire+issue in the same cycle
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    chk("t3_cnt2", pending_cnt_o, 2);
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("t3_full_stall", stall_o, 1);
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1);
    chk("t3_retire_issue_stall", stall_o, 0);
    step();
    chk("t3_cnt_stays2", pending_cnt_o, 2);
    chk("t3_err0", err_o, 0);
    drv(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("t3_x1_clear", stall_o, 0);
    drv(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("t3_x2_pend", stall_o, 1);
    drv(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("t3_x3_pend", stall_o, 1);
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2);
    step();
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3);
    step();
    idle();
    chk("t3_drained", pending_cnt_o, 0);

    // 4: WAW and unused-operand cases
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("t4_waw", stall_o, 1);
    drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("t4_addi_x0", stall_o, 0);
    drv(1'b1, 5'd0, 1'b1, 5'd7, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("t4_rs2_unused", stall_o, 0);
    drv(1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("t4_rs2_used", stall_o, 1);
    drv(1'b0, 5'd0, 1'b1, 5'd7, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("t4_invalid_no_stall", stall_o, 0);
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7);
    step();
    idle();
    chk("t4_drained", pending_cnt_o, 0);

    // 5: loads to x0 count but never scoreboard
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    chk("t5_cnt1", pending_cnt_o, 1);
    drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("t5_read_x0", stall_o, 0);
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("t5_lw_x0_again", stall_o, 0);
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
    step();
    idle();
    chk("t5_cnt0", pending_cnt_o, 0);
    chk("t5_err0", err_o, 0);

    // reset mid-operation drops pending state and ignores issue
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    rst = 1'b1;
    drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("rst_mid_stall", stall_o, 0);
    step();
    rst = 1'b0;
    drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("rst_mid_cnt", pending_cnt_o, 0);
    chk("rst_mid_sb", stall_o, 0);

    // issue while stalled at full depth: error, count saturates
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    idle();
    chk("sat_cnt", pending_cnt_o, 2);
    chk("sat_err", err_o, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("sat_rst_err", err_o, 0);

    // 6: flushed load issue is dropped; underflow is a sticky error
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0);
    chk("t6_flush_stall", stall_o, 0);
    step();
    drv(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("t6_flush_cnt", pending_cnt_o, 0);
    chk("t6_flush_sb", stall_o, 0);
    chk("t6_err0", err_o, 0);
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4);
    step();
    idle();
    chk("t6_uf_err", err_o, 1);
    chk("t6_uf_cnt", pending_cnt_o, 0);
    for (int i = 0; i < 10; i++) step();
    chk("t6_err_held", err_o, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_err_cleared", err_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
